// File: rtl/pack_fifo_nw.sv
// Narrow-write / wide-read packing FIFO with a first-word-fall-through output.
// Packs RATIO narrow words per RAM entry; in_last closes a partial entry early.
module pack_fifo_nw #(
  parameter int WIDTH_IN   = 8,
  parameter int RATIO      = 4,
  parameter int DEPTH_OUT  = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int LANE_WIDTH = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH_IN-1:0]          in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH_IN*RATIO-1:0]    out_data,
  output logic [LANE_WIDTH-1:0]        out_lanes,
  output logic                         out_last,
  output logic [ADDR_WIDTH:0]          level,
  output logic                         full,
  output logic                         empty
);

  localparam int DW = WIDTH_IN * RATIO;
  localparam int IW = LANE_WIDTH - 1;
  localparam int EW = DW + LANE_WIDTH + 1;
  localparam int CW = ADDR_WIDTH + 1;

  logic [EW-1:0] mem [DEPTH_OUT];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         mem_count_q, mem_count_d;
  logic [IW-1:0]         lane_q, lane_d;
  logic [DW-1:0]         pack_q, pack_d;
  logic                  out_valid_q, out_valid_d;
  logic [DW-1:0]         out_data_q, out_data_d;
  logic [LANE_WIDTH-1:0] out_lanes_q, out_lanes_d;
  logic                  out_last_q, out_last_d;
  logic                  full_q, full_d;

  logic                  accept, commit, load, pop;
  logic [DW-1:0]         pack_w;
  logic [LANE_WIDTH-1:0] lanes_w;
  logic [EW-1:0]         wr_ent, rd_ent;
  logic [CW:0]           lvl_sum;

  assign in_ready = ~full_q & ~reset;

  always_comb begin
    accept  = in_valid & in_ready;
    commit  = accept & ((lane_q == IW'(RATIO - 1)) | in_last);
    load    = (mem_count_q != '0) & (~out_valid_q | out_ready);
    pop     = out_valid_q & out_ready;
    pack_w  = pack_q;
    for (int i = 0; i < RATIO; i++) begin
      if (lane_q == IW'(i)) pack_w[i*WIDTH_IN +: WIDTH_IN] = in_data;
    end
    lanes_w = {1'b0, lane_q} + LANE_WIDTH'(1);
    wr_ent  = {in_last, lanes_w, pack_w};
    rd_ent  = mem[rd_ptr_q];

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_count_d = mem_count_q;
    lane_d      = lane_q;
    pack_d      = pack_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_lanes_d = out_lanes_q;
    out_last_d  = out_last_q;

    if (accept) begin
      if (commit) begin
        lane_d   = '0;
        pack_d   = '0;
        wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      end else begin
        lane_d = lane_q + IW'(1);
        pack_d = pack_w;
      end
    end

    // A pop with nothing behind it drops valid but keeps the old payload.
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = rd_ent[DW-1:0];
      out_lanes_d = rd_ent[DW +: LANE_WIDTH];
      out_last_d  = rd_ent[EW-1];
      rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(1);
    end else if (pop) begin
      out_valid_d = 1'b0;
    end

    unique case (1'b1)
      (commit & ~load): mem_count_d = mem_count_q + CW'(1);
      (load & ~commit): mem_count_d = mem_count_q - CW'(1);
      default:          mem_count_d = mem_count_q;
    endcase

    full_d = (mem_count_d == CW'(DEPTH_OUT));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_count_q <= '0;
      lane_q      <= '0;
      pack_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_lanes_q <= '0;
      out_last_q  <= 1'b0;
      full_q      <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_count_q <= mem_count_d;
      lane_q      <= lane_d;
      pack_q      <= pack_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_lanes_q <= out_lanes_d;
      out_last_q  <= out_last_d;
      full_q      <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (commit) mem[wr_ptr_q] <= wr_ent;
  end

  assign lvl_sum   = {1'b0, mem_count_q} + (CW+1)'(out_valid_q);
  assign level     = lvl_sum[CW] ? '1 : lvl_sum[CW-1:0];
  assign empty     = (level == '0) & (lane_q == '0);
  assign full      = full_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_lanes = out_lanes_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_pack_fifo_nw.sv
// Randomized bench for pack_fifo_nw against a queue-based packing model.
// Directed scenarios cover packing, flush, fill, wrap and mid-run reset.
module tb_pack_fifo_nw;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_last;
  logic [7:0]  in_data;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_data;
  logic [2:0]  out_lanes;
  logic [6:0]  level;
  logic        full, empty;

  pack_fifo_nw dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_lanes(out_lanes),
    .out_last(out_last), .level(level),
    .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    int          lanes;
    bit          last;
  } ent_t;

  ent_t        q[$];
  logic [7:0]  pk[4];
  int          pidx;
  bit          m_ov, m_olast, m_rst;
  logic [31:0] m_od;
  int          m_olanes;
  int          commits;
  int          n_chk = 0;
  int          n_pass = 0;
  int          maxlvl = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic m_reset();
    q.delete();
    for (int i = 0; i < 4; i++) pk[i] = 8'h00;
    pidx = 0; m_ov = 0; m_olast = 0; m_od = '0; m_olanes = 0;
  endtask

  task automatic check_all();
    int lv;
    lv = q.size() + (m_ov ? 1 : 0);
    chk("in_ready", in_ready, !m_rst && q.size() != 64);
    chk("out_valid", out_valid, m_ov);
    chk("out_data", out_data, m_od);
    chk("out_lanes", out_lanes, m_olanes);
    chk("out_last", out_last, m_olast);
    chk("level", level, lv);
    chk("full", full, q.size() == 64);
    chk("empty", empty, lv == 0 && pidx == 0);
    if (int'(level) > maxlvl) maxlvl = int'(level);
  endtask

  task automatic step(input bit iv, input logic [7:0] d,
                      input bit il, input bit ordy);
    bit   acc, cmt, ld;
    ent_t e;
    in_valid = iv; in_data = d; in_last = il; out_ready = ordy;
    acc = iv && q.size() != 64;
    ld  = q.size() > 0 && (!m_ov || ordy);
    cmt = 0;
    if (acc) begin
      pk[pidx] = d;
      if (pidx == 3 || il) begin
        e.d = {pk[3], pk[2], pk[1], pk[0]};
        e.lanes = pidx + 1;
        e.last = il;
        cmt = 1;
        for (int i = 0; i < 4; i++) pk[i] = 8'h00;
        pidx = 0;
      end else begin
        pidx++;
      end
    end
    if (ld) begin
      ent_t h;
      h = q.pop_front();
      m_ov = 1; m_od = h.d; m_olanes = h.lanes; m_olast = h.last;
    end else if (m_ov && ordy) begin
      m_ov = 0;
    end
    if (cmt) begin
      q.push_back(e);
      commits++;
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic drain();
    for (int i = 0; i < 80; i++) step(0, 8'h00, 0, 1);
  endtask

  initial begin
    int cyc;
    reset = 1; in_valid = 0; in_data = 0; in_last = 0; out_ready = 0;
    m_rst = 1; commits = 0;
    m_reset();
    repeat (2) @(negedge clk);
    check_all();
    reset = 0; m_rst = 0;
    #1 check_all();

    step(1, 8'h11, 0, 1); step(1, 8'h22, 0, 1);
    step(1, 8'h33, 0, 1); step(1, 8'h44, 0, 1);
    step(0, 8'h00, 0, 0);
    chk("pk4_data", out_data, 32'h44332211);
    chk("pk4_lanes", out_lanes, 3'd4);
    chk("pk4_last", out_last, 1'b0);
    step(0, 8'h00, 0, 1);
    chk("pk4_empty", empty, 1'b1);

    step(1, 8'hA1, 0, 1); step(1, 8'hA2, 1, 1);
    step(0, 8'h00, 0, 0);
    chk("flush_data", out_data, 32'h0000A2A1);
    chk("flush_lanes", out_lanes, 3'd2);
    chk("flush_last", out_last, 1'b1);
    drain();

    for (int i = 0; i < 260; i++) step(1, 8'(i), 0, 0);
    chk("fill_full", full, 1'b1);
    chk("fill_level", level, 7'd65);
    chk("fill_rdy", in_ready, 1'b0);
    step(1, 8'hEE, 0, 0);
    chk("stall_data", out_data, 32'h03020100);
    chk("stall_level", level, 7'd65);
    drain();

    cyc = 0;
    begin
      int target;
      target = commits + 200;
      while (commits < target && cyc < 5000) begin
        step($urandom_range(0, 3) != 0, 8'($urandom),
             $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
        cyc++;
      end
      chk("rand_budget", cyc < 5000, 1'b1);
    end
    while (pidx != 0) step(1, 8'($urandom), 1, 1);
    drain();
    chk("lvl_max", maxlvl <= 65, 1'b1);

    for (int i = 0; i < 16; i++) step(1, 8'(8'h40 + i), 0, 0);
    step(1, 8'h01, 0, 0); step(1, 8'h02, 0, 0); step(1, 8'h03, 0, 0);
    chk("cp_pre", level, 7'd4);
    step(1, 8'h04, 0, 1);
    chk("cp_post", level, 7'd4);
    chk("cp_data", out_data, 32'h47464544);
    drain();

    for (int i = 0; i < 26; i++) step(1, 8'(8'h80 + i), 0, 0);
    chk("pre_rst_lvl", level, 7'd6);
    reset = 1; m_rst = 1;
    m_reset();
    #1 check_all();
    chk("rst_ov", out_valid, 1'b0);
    chk("rst_lvl", level, 7'd0);
    chk("rst_empty", empty, 1'b1);
    @(posedge clk); @(negedge clk);
    check_all();
    reset = 0; m_rst = 0;
    #1 check_all();
    step(1, 8'h01, 0, 0); step(1, 8'h02, 0, 0);
    step(1, 8'h03, 0, 0); step(1, 8'h04, 0, 0);
    step(0, 8'h00, 0, 0);
    chk("post_rst_data", out_data, 32'h04030201);
    chk("post_rst_lanes", out_lanes, 3'd4);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pack_fifo_nw.md
Name: pack_fifo_nw

Overview:
- Single-clock, width-converting FIFO. Accepts narrow words of WIDTH_IN bits and packs RATIO of them into one wide word of WIDTH_IN*RATIO bits.
- Stores wide words in a DEPTH_OUT-entry RAM and presents them through a first-word-fall-through valid/ready output register.
- Successor to the dual-port narrow-write/wide-read RAM used in the pairhmm feed path. Adds flow control, occupancy tracking, partial-word flush via in_last, and lane-count reporting.

Parameters:
WIDTH_IN, 8, narrow input word width in bits (>=1)
RATIO, 4, narrow words per wide word; power of 2, >=2
DEPTH_OUT, 64, wide entries in RAM; power of 2, >=2
ADDR_WIDTH, 6, log2(DEPTH_OUT)
LANE_WIDTH, 3, log2(RATIO)+1

Ports:
clk  in  1  single clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  narrow word offered
in_ready  out  1  narrow word accepted when in_valid & in_ready
in_data  in  WIDTH_IN  narrow word
in_last  in  1  close current wide word after this narrow word
out_valid  out  1  wide word available
out_ready  in  1  wide word consumed when out_valid & out_ready
out_data  out  WIDTH_IN*RATIO  wide word; lane i = bits [(i+1)*WIDTH_IN-1 : i*WIDTH_IN]
out_lanes  out  LANE_WIDTH  number of valid lanes in out_data, 1..RATIO
out_last  out  1  wide word was closed by in_last
level  out  ADDR_WIDTH+1  RAM entries plus out_valid (0..DEPTH_OUT+1, saturates at field max)
full  out  1  RAM holds DEPTH_OUT entries
empty  out  1  level==0 and pack register holds no lanes

Behaviour:
- Reset (async assert, sync release):
  - wr_ptr, rd_ptr, mem_count, lane index and pack register cleared.
  - out_valid=0, out_data=0, out_lanes=0, out_last=0, level=0, full=0, empty=1.
  - in_ready=0 while reset is high.
  - RAM contents are not reset and are not relied upon.
- in_ready = !full & !reset. Partial-lane accepts are also blocked when full; this keeps the commit rule simple.
- Packing:
  - The accepted word goes to lane lane_idx, starting at lane 0. Lane 0 is the first word received (little-endian lane order).
  - Commit happens when lane_idx==RATIO-1 or in_last=1 on the accepting cycle.
  - On commit: {pack with this lane, lanes=lane_idx+1, last=in_last} is written to RAM[wr_ptr] at that edge; wr_ptr+1 wraps mod DEPTH_OUT; lane_idx returns to 0; pack register is zeroed.
  - Unwritten lanes of a partial word read as 0.
  - in_last on lane RATIO-1 gives lanes=RATIO, last=1.
- Output stage (FWFT):
  - Load condition: mem_count>0 and (!out_valid or out_ready).
  - On load: RAM[rd_ptr] is registered into out_data, out_lanes and out_last; rd_ptr+1 wraps; out_valid=1.
  - If there is a pop and mem_count==0, out_valid goes 0 and out_data holds its old value.
  - A RAM write followed by a read of the same entry is legal: the write lands at edge N, and the earliest load is edge N+1.
  - Latency: last narrow word accepted at edge N gives out_valid=1 after edge N+1 when the output is idle.
- Counters:
  - mem_count +1 on commit, -1 on load. A simultaneous commit and load leaves it unchanged.
  - full = (mem_count==DEPTH_OUT), registered from mem_count.
  - level = mem_count + out_valid.
- Wrap-around: pointers are ADDR_WIDTH bits and wrap naturally. Full/empty are decided by mem_count only, never by pointer equality.
- Protocol rules:
  - in_valid may drop without acceptance, and data is not latched.
  - out_data, out_lanes and out_last are stable while out_valid & !out_ready.
- Reset mid-operation: everything is discarded immediately, including a partial pack; in_ready is low until release.

Test Plan:
- Reset, then write 0x11,0x22,0x33,0x44 with out_ready=1 -> out_data=0x44332211, out_lanes=4, out_last=0 one cycle after the 4th accept; then empty=1.
- Write 0xA1,0xA2 with in_last on 0xA2 -> out_data=0x0000A2A1, out_lanes=2, out_last=1.
- out_ready=0, push 65 full wide words (260 narrow words) -> full=1 and level=65 once the RAM holds 64 and out_valid=1; in_ready=0; the 261st word is stalled and data is unchanged. Then pop all in order with no loss.
- Stream 200 wide words with random in_valid/out_ready -> pointer wrap is exercised; output sequence equals input sequence; level never exceeds 65.
- Commit and pop on the same cycle with mem_count=3 -> mem_count stays 3; level is unchanged.
- Assert reset after 2 lanes packed and 5 entries stored -> out_valid=0, level=0, empty=1 immediately. After release, the next 4 writes give a clean word with no stale lanes.
